// File: rtl/exec_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_pkg
// Purpose  : Shared opcode enum, FSM state type and branch constants for
//            the exec_alu block.
// Revision : 1.0 - initial release
// ============================================================================
package exec_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SRL  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_ROTR = 5'd8,
    OP_SVA  = 5'd9,
    OP_SVS  = 5'd10,
    OP_ABS  = 5'd11,
    OP_BEQ  = 5'd12,
    OP_BNE  = 5'd13,
    OP_BEQZ = 5'd14,
    OP_BNEZ = 5'd15,
    OP_JUMP = 5'd16,
    OP_JR   = 5'd17,
    OP_MUL  = 5'd18
  } aluctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic BranchTrue  = 1'b1;
  localparam logic BranchFalse = 1'b0;

endpackage
`default_nettype wire

// File: rtl/exec_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_if
// Purpose  : Operation/result handshake bundle between issue logic and
//            exec_alu.
// Revision : 1.0 - initial release
// ============================================================================
interface exec_alu_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  import exec_alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  aluctrl_e          aluctrl;
  logic [WIDTH-1:0]  src1;
  logic [WIDTH-1:0]  src2;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] branch_off;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              overflow;
  logic              branch_true;
  logic [ADDR_W-1:0] new_addr;
  logic              busy;

  modport slave (
    input  in_valid, aluctrl, src1, src2, pc, branch_off, flush, out_ready,
    output in_ready, out_valid, result, overflow, branch_true, new_addr, busy
  );

  modport master (
    output in_valid, aluctrl, src1, src2, pc, branch_off, flush, out_ready,
    input  in_ready, out_valid, result, overflow, branch_true, new_addr, busy
  );

endinterface
`default_nettype wire

// File: rtl/exec_alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_mul
// Purpose  : Iterative shift-add unsigned multiplier, one partial product per
//            cycle; done marks the final iteration with product valid.
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic               active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_next;

  // product is the accumulator including this cycle's partial product
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = active_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product  = acc_next;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (abort) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, op_a};
      mplier_d = op_b;
      acc_d    = '0;
    end else if (active_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu
// Purpose  : Execute-stage ALU with valid/ready handshake and branch
//            resolution; define EXEC_ALU_MUL_EN to add the iterative MUL op.
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu
  import exec_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  exec_alu_if.slave bus
);

  localparam int               SH_W     = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              branch_true_q, branch_true_d;
  logic [ADDR_W-1:0] new_addr_q, new_addr_d;

  logic              in_ready;
  logic              accept;
  logic [WIDTH-1:0]  sum, diff, abs_val;
  logic              add_ovf, sub_ovf;
  logic [SH_W-1:0]   shamt;
  logic [ADDR_W-1:0] br_target;

  logic [WIDTH-1:0]  op_result;
  logic              op_overflow;
  logic              op_branch;
  logic [ADDR_W-1:0] op_addr;

  assign in_ready  = (state_q == IDLE) && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;

  assign sum       = bus.src1 + bus.src2;
  assign diff      = bus.src1 - bus.src2;
  assign add_ovf   = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) && (sum[WIDTH-1] != bus.src1[WIDTH-1]);
  assign sub_ovf   = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) && (diff[WIDTH-1] != bus.src1[WIDTH-1]);
  assign abs_val   = bus.src1[WIDTH-1] ? ('0 - bus.src1) : bus.src1;
  assign shamt     = bus.src2[SH_W-1:0];
  assign br_target = bus.pc + bus.branch_off;

  always_comb begin
    op_result   = '0;
    op_overflow = 1'b0;
    op_branch   = BranchFalse;
    op_addr     = '0;
    case (bus.aluctrl)
      OP_ADD:  begin op_result = sum;  op_overflow = add_ovf; end
      OP_SUB:  begin op_result = diff; op_overflow = sub_ovf; end
      OP_AND:  op_result = bus.src1 & bus.src2;
      OP_OR:   op_result = bus.src1 | bus.src2;
      OP_XOR:  op_result = bus.src1 ^ bus.src2;
      OP_SRL:  op_result = bus.src1 >> shamt;
      OP_SLL:  op_result = bus.src1 << shamt;
      OP_SRA:  op_result = $unsigned($signed(bus.src1) >>> shamt);
      // rotate as the low half of the self-concatenation shifted right
      OP_ROTR: op_result = WIDTH'({bus.src1, bus.src1} >> shamt);
      OP_SVA:  begin op_result = {{(WIDTH-1){1'b0}}, add_ovf}; op_overflow = add_ovf; end
      OP_SVS:  begin op_result = {{(WIDTH-1){1'b0}}, sub_ovf}; op_overflow = sub_ovf; end
      OP_ABS:  begin op_result = abs_val; op_overflow = (bus.src1 == MOST_NEG); end
      OP_BEQ:  begin op_addr = br_target; op_branch = (bus.src1 == bus.src2) ? BranchTrue : BranchFalse; end
      OP_BNE:  begin op_addr = br_target; op_branch = (bus.src1 != bus.src2) ? BranchTrue : BranchFalse; end
      OP_BEQZ: begin op_addr = br_target; op_branch = (bus.src1 == '0) ? BranchTrue : BranchFalse; end
      OP_BNEZ: begin op_addr = br_target; op_branch = (bus.src1 != '0) ? BranchTrue : BranchFalse; end
      OP_JUMP: begin op_addr = br_target; op_branch = BranchTrue; end
      OP_JR:   begin op_addr = ADDR_W'(bus.src2 >> 2); op_branch = BranchTrue; end
      default: ;
    endcase
  end

`ifdef EXEC_ALU_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = accept && (bus.aluctrl == OP_MUL);

  exec_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (bus.flush),
    .op_a    (bus.src1),
    .op_b    (bus.src2),
    .done    (mul_done),
    .product (mul_product)
  );

  assign bus.busy = (state_q == MUL);
`else
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    result_d      = result_q;
    overflow_d    = overflow_q;
    branch_true_d = branch_true_q;
    new_addr_d    = new_addr_q;
    // flush outranks both acceptance and consumption
    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
          if (accept) begin
`ifdef EXEC_ALU_MUL_EN
            if (bus.aluctrl == OP_MUL) begin
              state_d = MUL;
            end else
`endif
            begin
              result_d      = op_result;
              overflow_d    = op_overflow;
              branch_true_d = op_branch;
              new_addr_d    = op_addr;
              out_valid_d   = 1'b1;
            end
          end
        end
`ifdef EXEC_ALU_MUL_EN
        MUL: begin
          if (mul_done) begin
            state_d       = HOLD;
            result_d      = mul_product[WIDTH-1:0];
            overflow_d    = |mul_product[2*WIDTH-1:WIDTH];
            branch_true_d = BranchFalse;
            new_addr_d    = '0;
            out_valid_d   = 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
      branch_true_q <= BranchFalse;
      new_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      result_q      <= result_d;
      overflow_q    <= overflow_d;
      branch_true_q <= branch_true_d;
      new_addr_q    <= new_addr_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.overflow    = overflow_q;
  assign bus.branch_true = branch_true_q;
  assign bus.new_addr    = new_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_alu
// Purpose  : Directed scoreboard bench for exec_alu (expectations follow
//            EXEC_ALU_MUL_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_alu;
  import exec_alu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 32;

  typedef struct {
    string       name;
    logic [31:0] result;
    logic        overflow;
    logic        branch_true;
    logic [31:0] new_addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle    = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  exec_alu_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

  exec_alu #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, ".result"},      bus_if.result,      e.result);
        check({e.name, ".overflow"},    bus_if.overflow,    e.overflow);
        check({e.name, ".branch_true"}, bus_if.branch_true, e.branch_true);
        check({e.name, ".new_addr"},    bus_if.new_addr,    e.new_addr);
      end
    end
  end

  task automatic drive(input aluctrl_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] off);
    bus_if.aluctrl    = op;
    bus_if.src1       = a;
    bus_if.src2       = b;
    bus_if.pc         = p;
    bus_if.branch_off = off;
    bus_if.in_valid   = 1'b1;
  endtask

  task automatic idle();
    bus_if.in_valid = 1'b0;
    bus_if.src1     = 32'hDEAD_BEEF;
    bus_if.src2     = 32'h1234_5679;
  endtask

  // Offer one op, push its expectation once acceptance is certain, return #1 after that edge.
  task automatic send(input string name, input aluctrl_e op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [31:0] off,
                      input logic [31:0] er, input logic eo, input logic eb, input logic [31:0] ea);
    int   waited;
    exp_t e;
    waited = 0;
    drive(op, a, b, p, off);
    @(negedge clk);
    while (bus_if.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus_if.in_ready !== 1'b1) begin
      check({name, ".accept_timeout"}, 64'd0, 64'd1);
    end else begin
      e.name = name; e.result = er; e.overflow = eo; e.branch_true = eb; e.new_addr = ea;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef EXEC_ALU_MUL_EN
  task automatic mul_run(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eo);
    int nb;
    int ir_ok;
    nb = 0;
    ir_ok = 1;
    send(name, OP_MUL, a, b, 32'h0, 32'h0, er, eo, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    while (bus_if.busy === 1'b1 && nb < 100) begin
      nb++;
      if (bus_if.in_ready !== 1'b0) ir_ok = 0;
      @(negedge clk);
    end
    check({name, ".busy_cycles"}, nb, 32);
    check({name, ".in_ready_low_while_busy"}, ir_ok, 1);
    check({name, ".out_valid_after_busy"}, bus_if.out_valid, 1'b1);
    drain();
  endtask
`endif

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 2000", cycle);
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int stable;
    int saw;
    rst = 1'b1;
    bus_if.in_valid   = 1'b0;
    bus_if.aluctrl    = OP_ADD;
    bus_if.src1       = '0;
    bus_if.src2       = '0;
    bus_if.pc         = '0;
    bus_if.branch_off = '0;
    bus_if.flush      = 1'b0;
    bus_if.out_ready  = 1'b1;

    repeat (2) @(negedge clk);
    check("rst.out_valid",   bus_if.out_valid,   1'b0);
    check("rst.result",      bus_if.result,      32'h0);
    check("rst.overflow",    bus_if.overflow,    1'b0);
    check("rst.branch_true", bus_if.branch_true, 1'b0);
    check("rst.new_addr",    bus_if.new_addr,    32'h0);
    check("rst.busy",        bus_if.busy,        1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", bus_if.in_ready, 1'b1);
    @(posedge clk); #1;

    // Latency-1: output visible right after the acceptance edge.
    send("add_max", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 1'b0, 32'h0);
    idle();
    @(negedge clk);
    check("add_latency.out_valid", bus_if.out_valid, 1'b1);
    drain();

    // Back-to-back stream with out_ready held high.
    t0 = cycle;
    send("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h2,         32'h0, 32'h0, 32'h1,         1'b0, 1'b0, 32'h0);
    send("sub_ovf",  OP_SUB,  32'h8000_0000, 32'h1,         32'h0, 32'h0, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h0);
    send("sub_neg",  OP_SUB,  32'h5,         32'h7,         32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    send("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 32'hF000_F000, 1'b0, 1'b0, 32'h0);
    send("or",       OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 32'hFFF0_FFF0, 1'b0, 1'b0, 32'h0);
    send("xor",      OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 32'h0FF0_0FF0, 1'b0, 1'b0, 32'h0);
    send("srl",      OP_SRL,  32'h8000_0000, 32'h4,         32'h0, 32'h0, 32'h0800_0000, 1'b0, 1'b0, 32'h0);
    send("sll_mask", OP_SLL,  32'h1,         32'h3F,        32'h0, 32'h0, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
    send("sra",      OP_SRA,  32'h8000_0000, 32'h4,         32'h0, 32'h0, 32'hF800_0000, 1'b0, 1'b0, 32'h0);
    send("rotr",     OP_ROTR, 32'h8000_0001, 32'h21,        32'h0, 32'h0, 32'hC000_0000, 1'b0, 1'b0, 32'h0);
    send("sva_ovf",  OP_SVA,  32'h7FFF_FFFF, 32'h1,         32'h0, 32'h0, 32'h1,         1'b1, 1'b0, 32'h0);
    send("svs_ok",   OP_SVS,  32'h1,         32'h2,         32'h0, 32'h0, 32'h0,         1'b0, 1'b0, 32'h0);
    send("svs_ovf",  OP_SVS,  32'h8000_0000, 32'h1,         32'h0, 32'h0, 32'h1,         1'b1, 1'b0, 32'h0);
    send("abs_neg",  OP_ABS,  32'hFFFF_FFFB, 32'h0,         32'h0, 32'h0, 32'h5,         1'b0, 1'b0, 32'h0);
    send("beq_t",    OP_BEQ,  32'h5, 32'h5, 32'h100,        32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, 32'hF0);
    send("bne_f",    OP_BNE,  32'h5, 32'h5, 32'h100,        32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 32'hF0);
    send("beqz_t",   OP_BEQZ, 32'h0, 32'h9, 32'h1000,       32'h20,        32'h0, 1'b0, 1'b1, 32'h1020);
    send("bnez_f",   OP_BNEZ, 32'h0, 32'h9, 32'h1000,       32'h20,        32'h0, 1'b0, 1'b0, 32'h1020);
    send("bnez_t",   OP_BNEZ, 32'h3, 32'h9, 32'h1000,       32'h20,        32'h0, 1'b0, 1'b1, 32'h1020);
    send("jump",     OP_JUMP, 32'h0, 32'h0, 32'hFFFF_FFFC,  32'h8,         32'h0, 1'b0, 1'b1, 32'h4);
    send("jr",       OP_JR,   32'h7, 32'h400, 32'h50,       32'h60,        32'h0, 1'b0, 1'b1, 32'h100);
    send("undef",    aluctrl_e'(5'd31), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h100, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
`ifndef EXEC_ALU_MUL_EN
    send("mul_off",  OP_MUL,  32'h3, 32'h7, 32'h100, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    check("b2b_cycles", cycle - t0, 23);
`else
    check("b2b_cycles", cycle - t0, 22);
`endif
    drain();

    // Back-pressure: most-negative ABS held stable while out_ready is low.
    bus_if.out_ready = 1'b0;
    send("abs_min", OP_ABS, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 1'b1, 1'b0, 32'h0);
    idle();
    bus_if.in_valid = 1'b1;
    stable = 1;
    repeat (5) begin
      @(negedge clk);
      if (!(bus_if.out_valid === 1'b1 && bus_if.result === 32'h8000_0000 &&
            bus_if.overflow === 1'b1 && bus_if.in_ready === 1'b0)) stable = 0;
    end
    check("abs_hold_stable", stable, 1);
    @(posedge clk); #1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("abs_release.in_ready", bus_if.in_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abs_release.out_valid_clear", bus_if.out_valid, 1'b0);
    drain();

    // Flush a held single-cycle result while a new op is offered.
    bus_if.out_ready = 1'b0;
    drive(OP_ADD, 32'h1, 32'h2, 32'h0, 32'h0);
    @(negedge clk);
    check("hflush.accept_ready", bus_if.in_ready, 1'b1);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("hflush.held_valid", bus_if.out_valid, 1'b1);
    check("hflush.held_result", bus_if.result, 32'h3);
    @(posedge clk); #1;
    bus_if.flush = 1'b1;
    drive(OP_ADD, 32'h4, 32'h4, 32'h0, 32'h0);
    @(negedge clk);
    check("hflush.in_ready_during_flush", bus_if.in_ready, 1'b0);
    @(posedge clk); #1;
    bus_if.flush     = 1'b0;
    idle();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("hflush.out_valid_cleared", bus_if.out_valid, 1'b0);
    check("hflush.in_ready_after", bus_if.in_ready, 1'b1);
    drain();

`ifdef EXEC_ALU_MUL_EN
    mul_run("mul_ovf",   32'h0001_0000, 32'h0001_0000, 32'h0,  1'b1);
    mul_run("mul_small", 32'h3,         32'h7,         32'd21, 1'b0);

    // Reset in the middle of a multiply discards it.
    drive(OP_MUL, 32'h5, 32'h6, 32'h0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    idle();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mul_rst.result",    bus_if.result,    32'h0);
    check("mul_rst.out_valid", bus_if.out_valid, 1'b0);
    check("mul_rst.busy",      bus_if.busy,      1'b0);
    check("mul_rst.overflow",  bus_if.overflow,  1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_if.out_valid !== 1'b0) saw = 1;
    end
    check("mul_rst.no_result", saw, 0);
    drain();

    // Flush around iteration 10 aborts the multiply.
    drive(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    idle();
    repeat (9) @(posedge clk);
    #1;
    bus_if.flush = 1'b1;
    @(posedge clk); #1;
    bus_if.flush = 1'b0;
    @(negedge clk);
    check("mul_flush.in_ready", bus_if.in_ready, 1'b1);
    check("mul_flush.busy",     bus_if.busy,     1'b0);
    saw = 0;
    repeat (40) begin
      if (bus_if.out_valid !== 1'b0) saw = 1;
      @(negedge clk);
    end
    check("mul_flush.no_result", saw, 0);
    drain();
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
